rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one downstream resource among eight requesters. Each cycle it scans the request vector starting at a rotating pointer and picks the first active request, wrapping from index 7 to index 0. It registers a one-hot grant, holds that grant until the owner signals `done`, then advances the pointer so every requester gets fair access. It sits in front of any shared datapath, such as a bus port or a functional unit, that has eight request lines.

---
 rtl/rr_arbiter8_if.sv | 34 +++
 rtl/rr_arbiter8.sv | 169 ++++++++++++++++
 tb/tb_rr_arbiter8.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if -- request/grant bundle between the eight requesters and the
// round-robin arbiter.
//
// Signals:
//   req       [7:0]  request lines, bit i belongs to requester i (level)
//   done             current owner releases its grant
//   grant     [7:0]  one-hot grant, zero when nobody owns the resource
//   grant_idx [2:0]  binary index of the (last) granted requester
//   busy             high while a grant is being held
//   none             high whenever req is all zeros (combinational)
//   timeout          one-cycle pulse when the watchdog revokes a grant
//
// Modports:
//   master -- arbiter side: consumes req/done, drives the grant outputs
//   slave  -- requester side: drives req/done, observes the grant outputs
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       none;
  logic       timeout;

  modport master (
    input  req, done,
    output grant, grant_idx, busy, none, timeout
  );

  modport slave (
    output req, done,
    input  grant, grant_idx, busy, none, timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- eight-way round-robin arbiter for one shared resource.
//
// In IDLE the request vector is scanned starting at a rotating pointer and the
// first active requester wins. The winner gets a registered one-hot grant that
// is held, regardless of req, until it raises done. On release the pointer
// moves to the requester after the owner, and at least one IDLE cycle follows
// every grant so the resource always sees a clean handoff.
//
// Ports:
//   clk    -- rising-edge clock
//   reset  -- synchronous, active-high reset
//   bus    -- rr_arbiter8_if.master (req, done in; grant, grant_idx, busy,
//             none, timeout out)
//
// Parameter:
//   MAX_HOLD -- longest grant in cycles (2..255), only used with the watchdog.
//
// Build option:
//   RR_ARB_TIMEOUT_EN -- when defined, a grant held for MAX_HOLD cycles without
//   done is revoked and timeout pulses for one cycle. When undefined, timeout
//   is tied low and a grant lasts until done or reset.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input logic          clk,
  input logic          reset,
  rr_arbiter8_if.master bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Reject an out-of-range hold limit at elaboration time.
  if ((MAX_HOLD < 32'd2) || (MAX_HOLD > 32'd255)) begin : g_max_hold_range
    $error("rr_arbiter8: MAX_HOLD must be in 2..255");
  end

  // Rotate right by s: bit s of v lands in bit 0.
  function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] w;
    w = {v, v} >> s;
    return w[7:0];
  endfunction

  // Index of the lowest set bit; 0 when v is zero (caller qualifies with v != 0).
  function automatic logic [2:0] first_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] grant_idx_q, grant_idx_d;
  logic       busy_q, busy_d;
  logic [2:0] winner_s;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 32'd1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
`endif

  // Winner of the rotated search, mapped back to an absolute index (3-bit add wraps mod 8).
  assign winner_s = first_set(rotr8(bus.req, ptr_q)) + ptr_q;

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    busy_d      = busy_q;
`ifdef RR_ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req != 8'h00) begin
          state_d     = GRANT;
          grant_d     = 8'h01 << winner_s;
          grant_idx_d = winner_s;
          busy_d      = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_d  = '0;
`endif
        end else begin
          grant_d = 8'h00;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        if (bus.done) begin
          state_d = IDLE;
          grant_d = 8'h00;
          busy_d  = 1'b0;
          ptr_d   = grant_idx_q + 3'd1;
`ifdef RR_ARB_TIMEOUT_EN
        end else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 32'd1)) begin
          // Watchdog: same release path as done, plus the timeout pulse.
          state_d   = IDLE;
          grant_d   = 8'h00;
          busy_d    = 1'b0;
          ptr_d     = grant_idx_q + 3'd1;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
`else
        end else begin
          state_d = GRANT;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'h00;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      grant_q     <= 8'h00;
      grant_idx_q <= 3'd0;
      busy_q      <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      busy_q      <= busy_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.busy      = busy_q;
  assign bus.none      = (bus.req == 8'h00);
`ifdef RR_ARB_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8 -- self-checking bench for rr_arbiter8.
// A behavioural model (owner as an integer, pointer as an integer, cycle
// count of the current grant) predicts the outputs every cycle; directed
// sequences add hand-computed expectations at the interesting points.
// Inputs change 2 time units after the rising edge, outputs are sampled on
// the falling edge.
module tb_rr_arbiter8;

  localparam int MH = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  rr_arbiter8_if bus();

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner = -1;   // -1: nobody holds the resource
  int m_ptr   = 0;
  int m_last  = 0;
  int m_hold  = 0;    // cycles the current owner has held the grant
  bit m_to    = 1'b0;

  always @(posedge clk) begin
    int o, p, l, h;
    bit t;
    o = m_owner; p = m_ptr; l = m_last; h = m_hold; t = 1'b0;
    if (reset) begin
      o = -1; p = 0; l = 0; h = 0;
    end else if (o < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (o < 0 && bus.req[(p + k) % 8]) begin
          o = (p + k) % 8; l = o; h = 1;
        end
      end
    end else if (bus.done) begin
      p = (o + 1) % 8; o = -1;
    end else if (TO_EN && h == MH) begin
      p = (o + 1) % 8; o = -1; t = 1'b1;
    end else begin
      h = h + 1;
    end
    m_owner <= o; m_ptr <= p; m_last <= l; m_hold <= h; m_to <= t;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [7:0] eg;
    if (chk_en) begin
      eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
      chk("model_grant",     bus.grant,     eg);
      chk("model_grant_idx", bus.grant_idx, m_last);
      chk("model_busy",      bus.busy,      (m_owner >= 0));
      chk("model_none",      bus.none,      (bus.req == 8'h00));
      chk("model_timeout",   bus.timeout,   m_to);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] one8;
    one8 = 8'h01;
    reset = 1'b1; bus.req = 8'h00; bus.done = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_grant", bus.grant, 8'h00);
    chk("reset_busy",  bus.busy, 1'b0);
    chk("reset_idx",   bus.grant_idx, 3'd0);

    // Idle: nothing requested for 5 cycles.
    ticks(5);
    @(negedge clk);
    chk("idle_none",    bus.none, 1'b1);
    chk("idle_grant",   bus.grant, 8'h00);
    chk("idle_timeout", bus.timeout, 1'b0);

    // Wrap-around 0 -> 7 -> 0.
    bus.req = 8'h81;
    tick(); @(negedge clk);
    chk("wrap_g0", bus.grant, 8'h01);
    chk("wrap_i0", bus.grant_idx, 3'd0);
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    @(negedge clk);
    chk("wrap_gap", bus.grant, 8'h00);
    tick(); @(negedge clk);
    chk("wrap_g7", bus.grant, 8'h80);
    chk("wrap_i7", bus.grant_idx, 3'd7);
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    tick(); @(negedge clk);
    chk("wrap_g0b", bus.grant, 8'h01);
    bus.req = 8'h00; bus.done = 1'b1; tick(); bus.done = 1'b0;
    tick();

    // Fairness: everyone requesting, done held high.
    reset = 1'b1; tick(); reset = 1'b0;
    bus.req = 8'hFF; bus.done = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick(); @(negedge clk);
      chk("fair_grant", bus.grant, one8 << (k % 8));
      chk("fair_idx",   bus.grant_idx, k % 8);
      tick(); @(negedge clk);
      chk("fair_gap",   bus.busy, 1'b0);
    end
    bus.done = 1'b0; bus.req = 8'h00;
    tick();

    // done in IDLE is ignored: pointer stays at 1.
    bus.done = 1'b1; tick(); bus.done = 1'b0; tick();
    @(negedge clk);
    chk("idle_done_busy", bus.busy, 1'b0);
    bus.req = 8'h03;
    tick(); @(negedge clk);
    chk("idle_done_ptr", bus.grant, 8'h02);
    bus.req = 8'h00; bus.done = 1'b1; tick(); bus.done = 1'b0; tick();

    // Request changes during a grant to requester 3 are ignored.
    bus.req = 8'h08;
    tick(); @(negedge clk);
    chk("hold_g3", bus.grant, 8'h08);
    bus.req = 8'h20;
    ticks(3); @(negedge clk);
    chk("hold_g3_kept", bus.grant, 8'h08);
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    @(negedge clk);
    chk("hold_release", bus.grant, 8'h00);
    tick(); @(negedge clk);
    chk("hold_next_g5", bus.grant, 8'h20);
    bus.req = 8'h00; bus.done = 1'b1; tick(); bus.done = 1'b0; tick();

    // Long hold by requester 2 (pointer is 6 here).
    bus.req = 8'h04;
    tick(); @(negedge clk);
    chk("long_g2", bus.grant, 8'h04);
`ifdef RR_ARB_TIMEOUT_EN
    ticks(3); @(negedge clk);
    chk("to_still_held", bus.grant, 8'h04);
    tick(); @(negedge clk);
    chk("to_revoked", bus.grant, 8'h00);
    chk("to_pulse",   bus.timeout, 1'b1);
    bus.req = 8'h0C;
    tick(); @(negedge clk);
    chk("to_ptr3", bus.grant, 8'h08);
    chk("to_pulse_end", bus.timeout, 1'b0);
`else
    ticks(22); @(negedge clk);
    chk("nto_held", bus.grant, 8'h04);
    chk("nto_no_timeout", bus.timeout, 1'b0);
    bus.done = 1'b1; bus.req = 8'h00; tick(); bus.done = 1'b0;
    bus.req = 8'h0C;
    tick(); @(negedge clk);
    chk("nto_ptr3", bus.grant, 8'h08);
`endif
    bus.req = 8'h00; bus.done = 1'b1; tick(); bus.done = 1'b0; tick();

    // Reset in the middle of a grant to requester 4 (pointer is 4 here).
    bus.req = 8'h10;
    tick(); @(negedge clk);
    chk("rst_g4", bus.grant, 8'h10);
    reset = 1'b1; bus.req = 8'h11; tick(); reset = 1'b0;
    @(negedge clk);
    chk("rst_grant",   bus.grant, 8'h00);
    chk("rst_busy",    bus.busy, 1'b0);
    chk("rst_timeout", bus.timeout, 1'b0);
    tick(); @(negedge clk);
    chk("rst_ptr0", bus.grant, 8'h01);
    bus.done = 1'b1; tick(); bus.done = 1'b0; bus.req = 8'h00;
    ticks(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
